// File: rtl/mod_reg16_1to16.sv
// ---------------------------------------------------------------------------
// mod_reg16_1to16
//   Byte-to-block collector. Takes one W-bit byte per accepted handshake and
//   assembles N bytes into a block that is presented in parallel to the next
//   round stage. The block is held until the consumer acknowledges it with
//   rd_en. A simultaneous acknowledge and write refills with no bubble.
//
// Ports
//   clk       in   rising-edge clock
//   resetn    in   asynchronous active-low reset
//   i         in   incoming byte
//   wr_en     in   i is valid this cycle
//   rd_en     in   consumer takes the held block (meaningful in FULL only)
//   clr       in   synchronous flush (highest priority after reset)
//   ready     out  a byte offered this cycle will be accepted
//   o         out  assembled block, o[0] = first byte received
//   reg_full  out  o holds a complete block
//   n_wr      out  bytes stored in the current partial block (0..N-1)
//   ovf       out  sticky: a byte was offered while ready was low
// ---------------------------------------------------------------------------
module mod_reg16_1to16 #(
   parameter int unsigned N = 16,
   parameter int unsigned W = 8
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [W-1:0]                i,
   input  logic                        wr_en,
   input  logic                        rd_en,
   input  logic                        clr,
   output logic                        ready,
   output logic [N-1:0][W-1:0]         o,
   output logic                        reg_full,
   output logic [$clog2(N)-1:0]        n_wr,
   output logic                        ovf
);

   localparam int unsigned NW = $clog2(N);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [N-1:0][W-1:0]    aux_q,   aux_d;
   logic [NW-1:0]          n_wr_q,  n_wr_d;
   logic                   ovf_q,   ovf_d;

   logic                   ready_c;
   logic                   accept;

   // ready is combinational so an acknowledge in FULL can admit a byte at the
   // same edge.
   assign ready_c = (state_q == FILL) | rd_en;
   assign accept  = wr_en & ready_c;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= FILL;
         aux_q   <= '0;
         n_wr_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         aux_q   <= aux_d;
         n_wr_q  <= n_wr_d;
         ovf_q   <= ovf_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      aux_d   = aux_q;
      n_wr_d  = n_wr_q;
      ovf_d   = ovf_q;

      if (clr) begin
         state_d = FILL;
         aux_d   = '0;
         n_wr_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         // An acknowledge in FULL releases the block; n_wr is already 0 there,
         // so a same-cycle byte lands in slot 0 through the common path below.
         if (state_q == FULL && rd_en) begin
            state_d = FILL;
         end

         if (accept) begin
            aux_d[n_wr_q] = i;
            if (n_wr_q == NW'(N - 1)) begin
               n_wr_d  = '0;
               state_d = FULL;
            end else begin
               n_wr_d  = n_wr_q + NW'(1);
            end
         end else if (wr_en) begin
            ovf_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      ready    = ready_c;
      o        = aux_q;
      reg_full = (state_q == FULL);
      n_wr     = n_wr_q;
      ovf      = ovf_q;
   end

endmodule

// File: tb/tb_mod_reg16_1to16.sv
module tb_mod_reg16_1to16;

   logic               clk;
   logic               resetn;
   logic [7:0]         i;
   logic               wr_en;
   logic               rd_en;
   logic               clr;
   logic               ready;
   logic [15:0][7:0]   o;
   logic               reg_full;
   logic [3:0]         n_wr;
   logic               ovf;

   int unsigned vectors;
   int unsigned miscompares;

   // Reference model: a 16-slot byte store, a fill count and two flags.
   logic [7:0]  m_mem [16];
   int unsigned m_cnt;
   bit          m_full;
   bit          m_ovf;

   mod_reg16_1to16 #(.N(16), .W(8)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .i        (i),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .clr      (clr),
      .ready    (ready),
      .o        (o),
      .reg_full (reg_full),
      .n_wr     (n_wr),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
      m_cnt  = 0;
      m_full = 0;
      m_ovf  = 0;
   endtask

   task automatic model_edge(input bit wr, input bit rd, input bit cl, input logic [7:0] d);
      bit rdy;
      if (cl) begin
         model_reset();
      end else begin
         rdy = !m_full || rd;
         if (m_full && rd) m_full = 0;
         if (wr && rdy) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 16) begin
               m_cnt  = 0;
               m_full = 1;
            end
         end else if (wr) begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [15:0][7:0] exp_o;
      for (int k = 0; k < 16; k++) exp_o[k] = m_mem[k];
      vectors++;
      assert (o === exp_o) else begin
         miscompares++;
         $error("FAIL %s o got %h exp %h", tag, o, exp_o);
      end
      assert (reg_full === m_full) else begin
         miscompares++;
         $error("FAIL %s reg_full got %b exp %b", tag, reg_full, m_full);
      end
      assert (n_wr === 4'(m_cnt)) else begin
         miscompares++;
         $error("FAIL %s n_wr got %0d exp %0d", tag, n_wr, m_cnt);
      end
      assert (ovf === m_ovf) else begin
         miscompares++;
         $error("FAIL %s ovf got %b exp %b", tag, ovf, m_ovf);
      end
   endtask

   task automatic check_ready(input string tag, input bit rd);
      logic exp_rdy;
      exp_rdy = !m_full || rd;
      assert (ready === exp_rdy) else begin
         miscompares++;
         $error("FAIL %s ready got %b exp %b", tag, ready, exp_rdy);
      end
   endtask

   // Called just after an active edge: drive, check ready, clock, check state.
   task automatic step(input string tag, input bit wr, input bit rd, input bit cl,
                       input logic [7:0] d);
      wr_en = wr;
      rd_en = rd;
      clr   = cl;
      i     = d;
      #1;
      check_ready(tag, rd);
      @(posedge clk);
      model_edge(wr, rd, cl, d);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 8'h00);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      wr_en  = 0;
      rd_en  = 0;
      clr    = 0;
      i      = 8'h00;
      resetn = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      check_ready("reset", 0);
      resetn = 1;

      // 1. Back-to-back fill with 00..0F
      for (int k = 0; k < 16; k++) step("fill_b2b", 1, 0, 0, 8'(k));
      idle("full_hold");

      // 2. Write while full: dropped, ovf sticky
      step("ovf_drop", 1, 0, 0, 8'hAA);
      idle("ovf_sticky");

      // 3. Simultaneous acknowledge and write
      step("rd_wr_same", 1, 1, 0, 8'h55);
      step("fill_rd_ignored", 0, 1, 0, 8'h00);

      // finish that block with random bytes and consume it
      for (int k = 1; k < 16; k++) step("fill_rand", 1, 0, 0, 8'($urandom));
      step("consume", 0, 1, 0, 8'h00);

      // 4. Gapped writes, one byte every third cycle
      for (int k = 0; k < 16; k++) begin
         step("gap_wr", 1, 0, 0, 8'($urandom));
         idle("gap_idle");
         idle("gap_idle");
      end
      step("consume2", 0, 1, 0, 8'h00);

      // 5. Seven bytes then clr with wr_en
      for (int k = 0; k < 7; k++) step("pre_clr", 1, 0, 0, 8'($urandom));
      step("clr_wr", 1, 0, 1, 8'hC3);
      idle("after_clr");

      // 6. Nine bytes then async reset between edges
      for (int k = 0; k < 9; k++) step("pre_rst", 1, 0, 0, 8'($urandom));
      wr_en  = 0;
      resetn = 0;
      #2;
      model_reset();
      check_outputs("async_rst");
      check_ready("async_rst", 0);
      #2;
      resetn = 1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 16; k++) step("refill", 1, 0, 0, 8'($urandom));
      idle("refill_full");

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         step("random",
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 49) == 0),
              8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

endmodule
